// File: rtl/fdivsqrt_pkg.sv
// Shared types and sizing helpers for the divide/sqrt iteration controller.
// Covers the format and state encodings, the mantissa widths and the counter sizing.
package fdivsqrt_pkg;

   typedef enum logic [1:0] {
      FMT_S = 2'b00,
      FMT_D = 2'b01,
      FMT_H = 2'b10,
      FMT_Q = 2'b11
   } fmt_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int NF_S = 23;
   localparam int NF_D = 52;
   localparam int NF_H = 10;
   localparam int NF_Q = 112;

   localparam int DEF_LOGR        = 1;
   localparam int DEF_DIVCOPIES   = 4;
   localparam int DEF_XLEN        = 64;
   localparam int DEF_IDIV_ON_FPU = 1;

   // Longest operation is either a Q divide or a full-width integer divide.
   function automatic int max_cycles(input int logr, input int rk, input int xlen, input int idiv_on_fpu);
      int q_bits;
      int i_bits;
      int q_cyc;
      int i_cyc;
      q_bits = NF_Q + 2 + logr;
      i_bits = (idiv_on_fpu != 0) ? (xlen + logr) : 0;
      q_cyc  = (q_bits - 1) / rk + 1;
      i_cyc  = (i_bits == 0) ? 0 : ((i_bits - 1) / rk + 1);
      return (q_cyc > i_cyc) ? q_cyc : i_cyc;
   endfunction

   function automatic int dur_len(input int logr, input int divcopies, input int xlen, input int idiv_on_fpu);
      return $clog2(max_cycles(logr, logr * divcopies, xlen, idiv_on_fpu) + 1);
   endfunction

   localparam int RK     = DEF_LOGR * DEF_DIVCOPIES;
   localparam int DURLEN = $clog2(max_cycles(DEF_LOGR, RK, DEF_XLEN, DEF_IDIV_ON_FPU) + 1);

endpackage

// File: rtl/fdivsqrt_cyclecalc.sv
// Combinational translation of an operation's result width into iteration cycles.
module fdivsqrt_cyclecalc
   import fdivsqrt_pkg::*;
#(
   parameter int LOGR        = 1,
   parameter int DIVCOPIES   = 4,
   parameter int XLEN        = 64,
   parameter int IDIV_ON_FPU = 1,
   parameter int IRB_W       = $clog2(XLEN + LOGR + 1),
   parameter int CYC_W       = DURLEN
) (
   input  logic [1:0]       FmtE,
   input  logic             SqrtE,
   input  logic             IntDivE,
   input  logic [IRB_W-1:0] IntResultBitsE,
   output logic [CYC_W-1:0] Cycles
);

   localparam int CW = CYC_W + 8;
   localparam logic [CW-1:0] RK_W   = CW'(LOGR * DIVCOPIES);
   localparam logic [CW-1:0] LOGR_W = CW'(LOGR);
   localparam logic [CW-1:0] ONE_W  = CW'(1);
   localparam logic [CW-1:0] TWO_W  = CW'(2);

   logic [CW-1:0] nf_s;
   logic [CW-1:0] bits_s;
   logic          int_op_s;

   // Result bits per operation, then ceil(bits / RK) iteration cycles.
   always_comb begin
      nf_s     = CW'(NF_D);
      int_op_s = IntDivE && (IDIV_ON_FPU != 0);
      case (fmt_e'(FmtE))
         FMT_S:   nf_s = CW'(NF_S);
         FMT_D:   nf_s = CW'(NF_D);
         FMT_H:   nf_s = CW'(NF_H);
         FMT_Q:   nf_s = CW'(NF_Q);
         default: nf_s = CW'(NF_D);
      endcase
      // A square root has an implicit integer bit, so it needs no integer digit.
      if (int_op_s) begin
         bits_s = CW'(IntResultBitsE);
      end else if (SqrtE) begin
         bits_s = nf_s + TWO_W;
      end else begin
         bits_s = nf_s + TWO_W + LOGR_W;
      end
      if (bits_s == {CW{1'b0}}) begin
         Cycles = {CYC_W{1'b0}};
      end else begin
         Cycles = CYC_W'((bits_s - ONE_W) / RK_W + ONE_W);
      end
   end

endmodule

// File: rtl/fdivsqrt_cyclectl.sv
// Iteration sequencer for the shared divide/sqrt datapath: accepts an operation,
// runs its iteration cycles under stall/flush and hands the result off via valid/ready.
module fdivsqrt_cyclectl
   import fdivsqrt_pkg::*;
#(
   parameter int LOGR        = 1,
   parameter int DIVCOPIES   = 4,
   parameter int XLEN        = 64,
   parameter int IDIV_ON_FPU = 1,
   localparam int IRB_W      = $clog2(XLEN + LOGR + 1),
   localparam int DUR_W      = dur_len(LOGR, DIVCOPIES, XLEN, IDIV_ON_FPU)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StartValid,
   output logic             StartReady,
   input  logic [1:0]       FmtE,
   input  logic             SqrtE,
   input  logic             IntDivE,
   input  logic [IRB_W-1:0] IntResultBitsE,
   input  logic             SpecialCaseE,
   input  logic             StallE,
   input  logic             FlushE,
   output logic             IterEn,
   output logic             FirstIter,
   output logic [DUR_W-1:0] CyclesLeft,
   output logic             DoneValid,
   input  logic             DoneReady
);

   state_e           state_r;
   state_e           state_s;
   logic [DUR_W-1:0] cnt_r;
   logic [DUR_W-1:0] cnt_s;
   logic             first_r;
   logic             first_s;
   logic [DUR_W-1:0] cycles_s;

   fdivsqrt_cyclecalc #(
      .LOGR        (LOGR),
      .DIVCOPIES   (DIVCOPIES),
      .XLEN        (XLEN),
      .IDIV_ON_FPU (IDIV_ON_FPU),
      .IRB_W       (IRB_W),
      .CYC_W       (DUR_W)
   ) u_cyclecalc (
      .FmtE           (FmtE),
      .SqrtE          (SqrtE),
      .IntDivE        (IntDivE),
      .IntResultBitsE (IntResultBitsE),
      .Cycles         (cycles_s)
   );

   // State, remaining-iteration counter and pending-first-iteration flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         first_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         first_r <= first_s;
      end
   end

   // Next-state logic; flush overrides acceptance, completion and handoff.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      first_s = first_r;
      if (FlushE) begin
         state_s = IDLE;
         cnt_s   = '0;
         first_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!StartValid) begin
                  state_s = IDLE;
               end else if (SpecialCaseE || (cycles_s == {DUR_W{1'b0}})) begin
                  state_s = DONE;
                  cnt_s   = '0;
               end else begin
                  state_s = BUSY;
                  cnt_s   = cycles_s;
                  first_s = 1'b1;
               end
            end
            BUSY: begin
               if (StallE) begin
                  state_s = BUSY;
               end else begin
                  first_s = 1'b0;
                  cnt_s   = cnt_r - DUR_W'(1);
                  state_s = (cnt_r == DUR_W'(1)) ? DONE : BUSY;
               end
            end
            DONE: begin
               state_s = DoneReady ? IDLE : DONE;
            end
            default: begin
               state_s = IDLE;
               cnt_s   = '0;
               first_s = 1'b0;
            end
         endcase
      end
   end

   assign StartReady = (state_r == IDLE);
   assign IterEn     = (state_r == BUSY) && !StallE;
   assign FirstIter  = IterEn && first_r;
   assign DoneValid  = (state_r == DONE);
   assign CyclesLeft = cnt_r;

endmodule

// File: tb/tb_fdivsqrt_cyclectl.sv
// Scoreboard bench for fdivsqrt_cyclectl: stimulus queues expected iteration
// counts and latencies, a negedge monitor measures and compares them.
module tb_fdivsqrt_cyclectl;

   localparam int IRB_W = 7;
   localparam int DUR_W = 5;

   logic             clk;
   logic             reset;
   logic             StartValid;
   logic             StartReady;
   logic [1:0]       FmtE;
   logic             SqrtE;
   logic             IntDivE;
   logic [IRB_W-1:0] IntResultBitsE;
   logic             SpecialCaseE;
   logic             StallE;
   logic             FlushE;
   logic             IterEn;
   logic             FirstIter;
   logic [DUR_W-1:0] CyclesLeft;
   logic             DoneValid;
   logic             DoneReady;

   typedef struct {
      string nm;
      int    iters;
      int    first;
      int    done;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   bit   active    = 1'b0;
   bit   done_seen = 1'b0;
   int   cyc       = 0;
   int   iters     = 0;
   int   first_cyc = -1;
   int   n_first   = 0;

   fdivsqrt_cyclectl dut (
      .clk            (clk),
      .reset          (reset),
      .StartValid     (StartValid),
      .StartReady     (StartReady),
      .FmtE           (FmtE),
      .SqrtE          (SqrtE),
      .IntDivE        (IntDivE),
      .IntResultBitsE (IntResultBitsE),
      .SpecialCaseE   (SpecialCaseE),
      .StallE         (StallE),
      .FlushE         (FlushE),
      .IterEn         (IterEn),
      .FirstIter      (FirstIter),
      .CyclesLeft     (CyclesLeft),
      .DoneValid      (DoneValid),
      .DoneReady      (DoneReady)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: measures each accepted operation and compares at the first DoneValid.
   always @(negedge clk) begin
      if (reset) begin
         active = 1'b0;
      end else begin
         if (active) begin
            cyc++;
            if (IterEn) iters++;
            if (FirstIter) begin
               n_first++;
               if (first_cyc < 0) first_cyc = cyc;
            end
            if (DoneValid && !done_seen) begin
               done_seen = 1'b1;
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL sb_underflow: got DoneValid, expected no operation");
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check({e.nm, "_iters"}, iters, e.iters);
                  check({e.nm, "_first_cyc"}, first_cyc, e.first);
                  check({e.nm, "_n_first"}, n_first, (e.first < 0) ? 0 : 1);
                  check({e.nm, "_done_cyc"}, cyc, e.done);
                  check({e.nm, "_left_at_done"}, int'(CyclesLeft), 0);
               end
            end
            if ((DoneValid && DoneReady) || FlushE) active = 1'b0;
         end
         if (StartValid && StartReady && !FlushE) begin
            active    = 1'b1;
            done_seen = 1'b0;
            cyc       = 0;
            iters     = 0;
            first_cyc = -1;
            n_first   = 0;
         end
      end
   end

   // Offer an operation and return in cycle 1, with the inputs scrambled.
   task automatic offer(input logic [1:0] fmt, input logic sq, input logic idv,
                        input logic [IRB_W-1:0] irb, input logic sp);
      int g;
      FmtE = fmt; SqrtE = sq; IntDivE = idv; IntResultBitsE = irb; SpecialCaseE = sp;
      StartValid = 1'b1;
      g = 0;
      while (!StartReady && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 50) check("accept_timeout", int'(StartReady), 1);
      @(posedge clk); #1;
      StartValid = 1'b0;
      FmtE = ~fmt; SqrtE = ~sq; IntDivE = ~idv; IntResultBitsE = 7'd33; SpecialCaseE = ~sp;
   endtask

   task automatic wait_done(input string nm, input logic [15:0] stall_mask);
      int g;
      g = 1;
      StallE = stall_mask[1];
      while (!DoneValid && g < 100) begin
         @(posedge clk); #1;
         g++;
         StallE = (g < 16) ? stall_mask[g] : 1'b0;
      end
      StallE = 1'b0;
      check({nm, "_done_seen"}, int'(DoneValid), 1);
   endtask

   task automatic run_op(input string nm, input logic [1:0] fmt, input logic sq, input logic idv,
                         input logic [IRB_W-1:0] irb, input logic sp, input logic [15:0] stall_mask,
                         input int e_iters, input int e_first, input int e_done);
      exp_t e;
      e.nm = nm; e.iters = e_iters; e.first = e_first; e.done = e_done;
      sb.push_back(e);
      offer(fmt, sq, idv, irb, sp);
      wait_done(nm, stall_mask);
      @(posedge clk); #1;
   endtask

   initial begin
      int dv_cnt;
      reset = 1'b1;
      StartValid = 1'b0; FmtE = 2'b00; SqrtE = 1'b0; IntDivE = 1'b0;
      IntResultBitsE = 7'd0; SpecialCaseE = 1'b0; StallE = 1'b0; FlushE = 1'b0;
      DoneReady = 1'b1;
      #3;
      check("rst_start_ready", int'(StartReady), 1);
      check("rst_iter_en", int'(IterEn), 0);
      check("rst_first_iter", int'(FirstIter), 0);
      check("rst_cycles_left", int'(CyclesLeft), 0);
      check("rst_done_valid", int'(DoneValid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      //     name        fmt    sq    idv   irb     sp    stalls         it  1st done
      run_op("d_div",    2'b01, 1'b0, 1'b0, 7'd0,  1'b0, 16'h0000,       14, 1, 15);
      run_op("h_sqrt",   2'b10, 1'b1, 1'b0, 7'd0,  1'b0, 16'h0000,        3, 1,  4);
      run_op("h_div",    2'b10, 1'b0, 1'b0, 7'd0,  1'b0, 16'h0000,        4, 1,  5);
      run_op("q_div",    2'b11, 1'b0, 1'b0, 7'd0,  1'b0, 16'h0000,       29, 1, 30);
      run_op("int_64",   2'b11, 1'b0, 1'b1, 7'd64, 1'b0, 16'h0000,       16, 1, 17);
      run_op("int_65",   2'b11, 1'b0, 1'b1, 7'd65, 1'b0, 16'h0000,       17, 1, 18);
      run_op("int_1",    2'b11, 1'b0, 1'b1, 7'd1,  1'b0, 16'h0000,        1, 1,  2);
      run_op("int_0",    2'b11, 1'b0, 1'b1, 7'd0,  1'b0, 16'h0000,        0, -1, 1);
      run_op("special",  2'b01, 1'b0, 1'b0, 7'd0,  1'b1, 16'h0000,        0, -1, 1);
      run_op("s_stall",  2'b00, 1'b0, 1'b0, 7'd0,  1'b0, 16'b0001_0110,   7, 3, 11);

      // Flush in BUSY with five iterations left.
      offer(2'b01, 1'b0, 1'b0, 7'd0, 1'b0);
      for (int g = 0; g < 30 && CyclesLeft != 5'd5; g++) begin
         @(posedge clk); #1;
      end
      check("flush_pre_left", int'(CyclesLeft), 5);
      FlushE = 1'b1;
      @(posedge clk); #1;
      FlushE = 1'b0;
      check("flush_start_ready", int'(StartReady), 1);
      check("flush_cycles_left", int'(CyclesLeft), 0);
      check("flush_done_valid", int'(DoneValid), 0);
      check("flush_iter_en", int'(IterEn), 0);
      dv_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (DoneValid) dv_cnt++;
      end
      check("flush_no_done", dv_cnt, 0);

      // Asynchronous reset mid-BUSY, checked before any clock edge.
      offer(2'b01, 1'b0, 1'b0, 7'd0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1 reset = 1'b1;
      #1;
      check("areset_start_ready", int'(StartReady), 1);
      check("areset_cycles_left", int'(CyclesLeft), 0);
      check("areset_iter_en", int'(IterEn), 0);
      check("areset_done_valid", int'(DoneValid), 0);
      @(posedge clk); #2;
      reset = 1'b0;
      dv_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (DoneValid) dv_cnt++;
      end
      check("areset_no_done", dv_cnt, 0);

      // Consumer back-pressure with a second operation waiting.
      begin
         exp_t e;
         e.nm = "hold_a"; e.iters = 3; e.first = 1; e.done = 4;
         sb.push_back(e);
         DoneReady = 1'b0;
         offer(2'b10, 1'b1, 1'b0, 7'd0, 1'b0);
         e.nm = "hold_b"; e.iters = 4; e.first = 1; e.done = 5;
         sb.push_back(e);
         FmtE = 2'b10; SqrtE = 1'b0; IntDivE = 1'b0; SpecialCaseE = 1'b0;
         StartValid = 1'b1;
         wait_done("hold_a", 16'h0000);
         for (int i = 0; i < 3; i++) begin
            check("hold_done_valid", int'(DoneValid), 1);
            check("hold_start_ready", int'(StartReady), 0);
            check("hold_cycles_left", int'(CyclesLeft), 0);
            @(posedge clk); #1;
         end
         check("hold_done_valid_c7", int'(DoneValid), 1);
         DoneReady = 1'b1;
         @(posedge clk); #1;
         check("handoff_start_ready", int'(StartReady), 1);
         check("handoff_done_valid", int'(DoneValid), 0);
         @(posedge clk); #1;
         check("second_accepted", int'(StartReady), 0);
         StartValid = 1'b0;
         wait_done("hold_b", 16'h0000);
         @(posedge clk); #1;
      end

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
